bomb_blast_ctrl: RTL

Consumes the 144-bit static wall map (12x12 grid, 1 = solid wall) and manages one bomb at a time.
- Accepts a placement request, counts a fuse in frame ticks, then walks the blast outward in four directions. The blast stops at walls and at the configured range.
- Presents the resulting flame map for a fixed number of frames.
- Sits directly downstream of the wall-map generator. Its flame map feeds the renderer and the player-hit logic.

---
 rtl/bomb_blast_ctrl_pkg.sv | 19 +
 rtl/bomb_blast_ctrl_if.sv | 45 ++++
 rtl/blast_flame_walker.sv | 99 +++++++++
 rtl/bomb_blast_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bomb_blast_ctrl_pkg.sv
// bomberman_pkg: grid geometry, the cell index helper, and the enums shared
// by the bomb blast controller, its flame walker and its bus interface.
//   GRID_W, GRID_H, CELLS : 12 x 12 grid, 144 cells
//   cell_idx(x,y)         : bit position of cell (x,y); row 0 sits at the MSBs
//   dir_t                 : blast walk direction, visited in enum order
//   blast_state_t         : controller state
package bomberman_pkg;
    localparam int GRID_W = 12;
    localparam int GRID_H = 12;
    localparam int CELLS  = 144;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, FUSE, PROP, FLAME} blast_state_t;

    // Only meaningful for in-grid coordinates; callers guard off-grid cells.
    function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return 8'(CELLS - 1 - (GRID_W * int'(y) + int'(x)));
    endfunction
endpackage

// File: rtl/bomb_blast_ctrl_if.sv
// Bus between the wall-map/placement source and bomb_blast_ctrl.
//   master : drives Frame_Tick, Wall_Map_In, Place_Req/X/Y, Range
//            (and Detonate when REMOTE_DETONATE_EN is defined)
//   slave  : drives Place_Ack/Nack, Bomb_Active/X/Y, Flame_Active,
//            Flame_Map, Blast_Done
// Macro REMOTE_DETONATE_EN adds the Detonate signal.
interface bomb_blast_ctrl_if;
    import bomberman_pkg::*;

    logic             Frame_Tick;
    logic [CELLS-1:0] Wall_Map_In;
    logic             Place_Req;
    logic [3:0]       Place_X;
    logic [3:0]       Place_Y;
    logic [1:0]       Range;
`ifdef REMOTE_DETONATE_EN
    logic             Detonate;
`endif
    logic             Place_Ack;
    logic             Place_Nack;
    logic             Bomb_Active;
    logic [3:0]       Bomb_X;
    logic [3:0]       Bomb_Y;
    logic             Flame_Active;
    logic [CELLS-1:0] Flame_Map;
    logic             Blast_Done;

    modport master (
        output Frame_Tick, Wall_Map_In, Place_Req, Place_X, Place_Y, Range,
`ifdef REMOTE_DETONATE_EN
        output Detonate,
`endif
        input  Place_Ack, Place_Nack, Bomb_Active, Bomb_X, Bomb_Y,
        input  Flame_Active, Flame_Map, Blast_Done
    );

    modport slave (
        input  Frame_Tick, Wall_Map_In, Place_Req, Place_X, Place_Y, Range,
`ifdef REMOTE_DETONATE_EN
        input  Detonate,
`endif
        output Place_Ack, Place_Nack, Bomb_Active, Bomb_X, Bomb_Y,
        output Flame_Active, Flame_Map, Blast_Done
    );
endinterface

// File: rtl/blast_flame_walker.sv
// Blast walker: on start, marks the centre cell, then walks up, down, left,
// right one candidate cell per cycle, up to rng steps each, stopping a
// direction at the grid edge or a wall in the snapshot.
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle pulse, begins a walk (accumulator cleared)
//   clear      : one-cycle pulse, drops the accumulator and aborts
//   cx, cy     : centre cell (in-grid)
//   rng        : clamped reach, 1..MAX_RANGE
//   walls      : wall snapshot
//   done       : high in the cycle the last candidate is evaluated
//   map        : accumulated flame cells
module blast_flame_walker
    import bomberman_pkg::*;
#(
    parameter int RW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [3:0]       cx,
    input  logic [3:0]       cy,
    input  logic [RW-1:0]    rng,
    input  logic [CELLS-1:0] walls,
    output logic             done,
    output logic [CELLS-1:0] map
);
    logic             busy, centre_ph, off, blocked, last;
    dir_t             dir;
    logic [RW-1:0]    step;
    logic [3:0]       px, py, nx, ny;
    logic [7:0]       cand_idx;
    logic [CELLS-1:0] acc;

    // Candidate = cursor moved one cell; the edge test comes first so the
    // 4-bit coordinate never wraps into a bogus in-grid cell.
    always_comb begin
        nx  = px;
        ny  = py;
        off = 1'b0;
        case (dir)
            UP:    begin off = (py == 4'd0);              ny = py - 4'd1; end
            DOWN:  begin off = (py == 4'(GRID_H - 1));    ny = py + 4'd1; end
            LEFT:  begin off = (px == 4'd0);              nx = px - 4'd1; end
            RIGHT: begin off = (px == 4'(GRID_W - 1));    nx = px + 4'd1; end
            default: off = 1'b1;
        endcase
        cand_idx = cell_idx(nx, ny);
        blocked  = off ? 1'b1 : walls[cand_idx];
        last     = blocked || (step == rng);
        done     = busy && !centre_ph && last && (dir == RIGHT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            centre_ph <= 1'b0;
            dir       <= UP;
            step      <= RW'(1);
            px        <= '0;
            py        <= '0;
            acc       <= '0;
        end else if (clear) begin
            busy <= 1'b0;
            acc  <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            centre_ph <= 1'b1;
            dir       <= UP;
            step      <= RW'(1);
            px        <= cx;
            py        <= cy;
            acc       <= '0;
        end else if (busy) begin
            if (centre_ph) begin
                acc[cell_idx(cx, cy)] <= 1'b1;
                centre_ph             <= 1'b0;
            end else begin
                if (!blocked) begin
                    acc[cand_idx] <= 1'b1;
                    px            <= nx;
                    py            <= ny;
                end
                if (last) begin
                    // Next direction restarts from the centre.
                    step <= RW'(1);
                    px   <= cx;
                    py   <= cy;
                    if (dir == RIGHT) busy <= 1'b0;
                    else              dir  <= dir_t'(dir + 2'd1);
                end else begin
                    step <= step + 1'b1;
                end
            end
        end
    end

    assign map = acc;
endmodule

// File: rtl/bomb_blast_ctrl.sv
// bomb_blast_ctrl: single-bomb controller. Accepts a placement on a clear
// in-grid cell, counts the fuse in frame ticks, runs the blast walker on a
// snapshot of the wall map, then shows the flame map for FLAME_FRAMES ticks.
//   Clk, Reset_n : clock, async active-low reset
//   bus (slave)  : placement request/response, wall map, frame tick, status
//                  and flame map (see bomb_blast_ctrl_if)
// Macro REMOTE_DETONATE_EN: Detonate in FUSE cuts the fuse short.
module bomb_blast_ctrl
    import bomberman_pkg::*;
#(
    parameter int FUSE_FRAMES  = 180,
    parameter int FLAME_FRAMES = 30,
    parameter int MAX_RANGE    = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    bomb_blast_ctrl_if.slave  bus
);
    localparam int CW = $clog2(((FUSE_FRAMES > FLAME_FRAMES) ? FUSE_FRAMES : FLAME_FRAMES) + 1);
    localparam int RW = $clog2(MAX_RANGE + 1);

    blast_state_t     state;
    logic [CW-1:0]    fuse_cnt, flame_cnt;
    logic [3:0]       bomb_x, bomb_y;
    logic [RW-1:0]    rng, rng_clamped;
    logic [CELLS-1:0] snap, walk_map;
    logic             place_ack, place_nack, bomb_active, flame_active, blast_done;
    logic             in_grid, target_ok, detonate, fire, flame_end, walk_done;
    logic [7:0]       tgt_idx;

`ifdef REMOTE_DETONATE_EN
    assign detonate = bus.Detonate;
`else
    assign detonate = 1'b0;
`endif

    always_comb begin
        in_grid   = (bus.Place_X < 4'(GRID_W)) && (bus.Place_Y < 4'(GRID_H));
        tgt_idx   = cell_idx(bus.Place_X, bus.Place_Y);
        target_ok = in_grid ? !bus.Wall_Map_In[tgt_idx] : 1'b0;
        if (bus.Range == 2'd0)                 rng_clamped = RW'(1);
        else if (int'(bus.Range) > MAX_RANGE)  rng_clamped = RW'(MAX_RANGE);
        else                                   rng_clamped = RW'(bus.Range);
        fire      = (state == FUSE) &&
                    ((bus.Frame_Tick && (fuse_cnt == CW'(FUSE_FRAMES - 1))) || detonate);
        flame_end = (state == FLAME) && bus.Frame_Tick &&
                    (flame_cnt == CW'(FLAME_FRAMES - 1));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            fuse_cnt     <= '0;
            flame_cnt    <= '0;
            bomb_x       <= '0;
            bomb_y       <= '0;
            rng          <= '0;
            snap         <= '0;
            place_ack    <= 1'b0;
            place_nack   <= 1'b0;
            bomb_active  <= 1'b0;
            flame_active <= 1'b0;
            blast_done   <= 1'b0;
        end else begin
            place_ack  <= 1'b0;
            blast_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.Place_Req) begin
                        place_nack <= 1'b0;
                    end else if (target_ok) begin
                        place_ack   <= 1'b1;
                        place_nack  <= 1'b0;
                        bomb_x      <= bus.Place_X;
                        bomb_y      <= bus.Place_Y;
                        rng         <= rng_clamped;
                        snap        <= bus.Wall_Map_In;
                        fuse_cnt    <= '0;
                        bomb_active <= 1'b1;
                        state       <= FUSE;
                    end else begin
                        // Held bad request: Nack alternates high/low.
                        place_nack <= !place_nack;
                    end
                end
                FUSE: begin
                    if (fire) begin
                        fuse_cnt    <= '0;
                        bomb_active <= 1'b0;
                        state       <= PROP;
                    end else if (bus.Frame_Tick) begin
                        fuse_cnt <= fuse_cnt + 1'b1;
                    end
                end
                PROP: begin
                    // Flame goes visible on the same edge that writes the
                    // last walker mark, so no partial map is ever shown.
                    if (walk_done) begin
                        flame_cnt    <= '0;
                        flame_active <= 1'b1;
                        state        <= FLAME;
                    end
                end
                FLAME: begin
                    if (flame_end) begin
                        flame_cnt    <= '0;
                        flame_active <= 1'b0;
                        blast_done   <= 1'b1;
                        state        <= IDLE;
                    end else if (bus.Frame_Tick) begin
                        flame_cnt <= flame_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    blast_flame_walker #(.RW(RW)) u_walker (
        .clk   (Clk),
        .rst_n (Reset_n),
        .start (fire),
        .clear (flame_end),
        .cx    (bomb_x),
        .cy    (bomb_y),
        .rng   (rng),
        .walls (snap),
        .done  (walk_done),
        .map   (walk_map)
    );

    assign bus.Place_Ack    = place_ack;
    assign bus.Place_Nack   = place_nack;
    assign bus.Bomb_Active  = bomb_active;
    assign bus.Bomb_X       = bomb_x;
    assign bus.Bomb_Y       = bomb_y;
    assign bus.Flame_Active = flame_active;
    assign bus.Flame_Map    = flame_active ? walk_map : '0;
    assign bus.Blast_Done   = blast_done;
endmodule
